// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: decodes one load/store per handshake, drives a
// word-addressed data-memory port and returns the aligned, extended load result.
module lsu_mem_stage #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_data,
  output logic              fault,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_next;
  logic            accept;
  logic            legal;
  logic            misaligned;
  logic            op_ok;
  logic [3:0]      strb;
  logic [XLEN-1:0] wdata_rep;
  logic [XLEN-1:0] load_val;
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [2:0]      op_funct3;
  logic [1:0]      op_off;

  assign req_ready = (state == IDLE);
  assign busy      = ~req_ready;
  assign accept    = req_valid && req_ready;
  assign op_ok     = legal && !misaligned;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case statements leaves it unassigned and infers a latch.
  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    strb       = 4'b0000;
    wdata_rep  = req_wdata;
    if (req_we) begin
      case (req_funct3)
        3'b000: begin
          legal     = 1'b1;
          strb      = 4'b0001 << req_addr[1:0];
          wdata_rep = {4{req_wdata[7:0]}};
        end
        3'b001: begin
          legal      = 1'b1;
          misaligned = req_addr[0];
          strb       = 4'b0011 << req_addr[1:0];
          wdata_rep  = {2{req_wdata[15:0]}};
        end
        3'b010: begin
          legal      = 1'b1;
          misaligned = (req_addr[1:0] != 2'b00);
          strb       = 4'b1111;
        end
        default: legal = 1'b0;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b100: legal = 1'b1;
        3'b001, 3'b101: begin
          legal      = 1'b1;
          misaligned = req_addr[0];
        end
        3'b010: begin
          legal      = 1'b1;
          misaligned = (req_addr[1:0] != 2'b00);
        end
        default: legal = 1'b0;
      endcase
    end
  end

  // Lane selection uses the offset latched at accept, not the live request.
  always_comb begin
    load_byte = mem_rdata[{op_off, 3'b000} +: 8];
    load_half = mem_rdata[{op_off[1], 4'b0000} +: 16];
    case (op_funct3)
      3'b000:  load_val = {{(XLEN-8){load_byte[7]}}, load_byte};
      3'b100:  load_val = {{(XLEN-8){1'b0}}, load_byte};
      3'b001:  load_val = {{(XLEN-16){load_half[15]}}, load_half};
      3'b101:  load_val = {{(XLEN-16){1'b0}}, load_half};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = op_ok ? WAIT : RESP;
      WAIT:    if (mem_ack) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      fault     <= 1'b0;
      op_funct3 <= 3'b000;
      op_off    <= 2'b00;
    end else begin
      rsp_valid <= 1'b0;
      fault     <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (op_ok) begin
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_wstrb <= req_we ? strb : 4'b0000;
              mem_wdata <= wdata_rep;
              op_funct3 <= req_funct3;
              op_off    <= req_addr[1:0];
            end else begin
              rsp_valid <= 1'b1;
              fault     <= 1'b1;
              rsp_data  <= '0;
            end
          end
        end
        WAIT: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= mem_we ? '0 : load_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed self-checking bench for lsu_mem_stage: loads, stores, faults,
// reset during an outstanding access and back-to-back requests.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        rsp_valid, fault, busy;
  logic [31:0] rsp_data;

  int total = 0;
  int bad   = 0;

  logic        obs_we, obs_req_first, obs_rv, obs_fault, obs_req_after;
  logic        obs_rv2, obs_fault2, obs_ready2, obs_req2;
  logic [31:0] obs_addr, obs_wdata, obs_data;
  logic [3:0]  obs_wstrb;
  int          obs_req_cyc;

  logic count_en = 1'b0;
  int   pulse_cnt;

  lsu_mem_stage #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .fault(fault), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!count_en)      pulse_cnt = 0;
    else if (rsp_valid) pulse_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op and records the port behaviour; ncyc = cycles mem_req stays
  // high before the ack (ack in the last of them), 0 for an op that must fault.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int ncyc);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    obs_req_first = mem_req; obs_we = mem_we; obs_addr = mem_addr;
    obs_wstrb = mem_wstrb; obs_wdata = mem_wdata;
    obs_req_cyc = 0;
    for (int i = 1; i <= ncyc; i++) begin
      if (mem_req) obs_req_cyc++;
      if (i == ncyc) begin mem_ack = 1'b1; mem_rdata = rdata; end
      tick();
      mem_ack = 1'b0; mem_rdata = 32'hCAFE_F00D;
    end
    obs_rv = rsp_valid; obs_data = rsp_data; obs_fault = fault; obs_req_after = mem_req;
    tick();
    obs_rv2 = rsp_valid; obs_fault2 = fault; obs_ready2 = req_ready; obs_req2 = mem_req;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = 32'hCAFE_F00D;
    tick(); tick();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    total++; if (mem_wstrb !== 4'h0) begin bad++; $display("FAIL reset_wstrb got=%b exp=0000", mem_wstrb); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fault); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lw();
    run_op(1'b0, 3'b010, 32'h104, 32'h0, 32'hDEAD_BEEF, 3);
    total++; if (obs_addr !== 32'h104) begin bad++; $display("FAIL lw_addr got=%h exp=00000104", obs_addr); end
    total++; if (obs_wstrb !== 4'b0000) begin bad++; $display("FAIL lw_wstrb got=%b exp=0000", obs_wstrb); end
    total++; if (obs_we !== 1'b0) begin bad++; $display("FAIL lw_we got=%b exp=0", obs_we); end
    total++; if (obs_req_cyc != 3) begin bad++; $display("FAIL lw_req_cycles got=%0d exp=3", obs_req_cyc); end
    total++; if (obs_req_after !== 1'b0) begin bad++; $display("FAIL lw_req_drop got=%b exp=0", obs_req_after); end
    total++; if (obs_rv !== 1'b1) begin bad++; $display("FAIL lw_rsp_valid got=%b exp=1", obs_rv); end
    total++; if (obs_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", obs_data); end
    total++; if (obs_fault !== 1'b0) begin bad++; $display("FAIL lw_fault got=%b exp=0", obs_fault); end
    total++; if (obs_rv2 !== 1'b0) begin bad++; $display("FAIL lw_rsp_pulse got=%b exp=0", obs_rv2); end
    total++; if (obs_ready2 !== 1'b1) begin bad++; $display("FAIL lw_ready_back got=%b exp=1", obs_ready2); end
    total++; if (rsp_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_data_hold got=%h exp=deadbeef", rsp_data); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ad  [4] = '{32'h203, 32'h203, 32'h202, 32'h200};
    logic [31:0] exp [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8011, 32'h0000_2233};
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, f3[i], ad[i], 32'h0, 32'h8011_2233, 1);
      total++; if (obs_addr !== 32'h200) begin bad++; $display("FAIL ext%0d_addr got=%h exp=00000200", i, obs_addr); end
      total++; if (obs_rv !== 1'b1) begin bad++; $display("FAIL ext%0d_rsp_valid got=%b exp=1", i, obs_rv); end
      total++; if (obs_data !== exp[i]) begin bad++; $display("FAIL ext%0d_data got=%h exp=%h", i, obs_data, exp[i]); end
    end
  endtask

  task automatic test_store();
    logic [2:0]  f3 [3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] ad [3] = '{32'h1002, 32'h1001, 32'h1008};
    logic [31:0] wd [3] = '{32'h0000_ABCD, 32'h0000_005A, 32'h1234_5678};
    logic [31:0] ea [3] = '{32'h1000, 32'h1000, 32'h1008};
    logic [3:0]  es [3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] ew [3] = '{32'hABCD_ABCD, 32'h5A5A_5A5A, 32'h1234_5678};
    for (int i = 0; i < 3; i++) begin
      run_op(1'b1, f3[i], ad[i], wd[i], 32'hFFFF_FFFF, 2);
      total++; if (obs_we !== 1'b1) begin bad++; $display("FAIL st%0d_we got=%b exp=1", i, obs_we); end
      total++; if (obs_addr !== ea[i]) begin bad++; $display("FAIL st%0d_addr got=%h exp=%h", i, obs_addr, ea[i]); end
      total++; if (obs_wstrb !== es[i]) begin bad++; $display("FAIL st%0d_wstrb got=%b exp=%b", i, obs_wstrb, es[i]); end
      total++; if (obs_wdata !== ew[i]) begin bad++; $display("FAIL st%0d_wdata got=%h exp=%h", i, obs_wdata, ew[i]); end
      total++; if (obs_req_cyc != 2) begin bad++; $display("FAIL st%0d_req_cycles got=%0d exp=2", i, obs_req_cyc); end
      total++; if (obs_rv !== 1'b1) begin bad++; $display("FAIL st%0d_rsp_valid got=%b exp=1", i, obs_rv); end
      total++; if (obs_data !== 32'h0) begin bad++; $display("FAIL st%0d_data got=%h exp=0", i, obs_data); end
    end
  endtask

  task automatic test_fault();
    logic        we [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3 [4] = '{3'b010, 3'b011, 3'b101, 3'b100};
    logic [31:0] ad [4] = '{32'h102, 32'h100, 32'h201, 32'h100};
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, 3'b010, 32'h400, 32'h0, 32'h5555_AAAA, 1);
      total++; if (obs_data !== 32'h5555_AAAA) begin bad++; $display("FAIL flt%0d_pre_data got=%h exp=5555aaaa", i, obs_data); end
      run_op(we[i], f3[i], ad[i], 32'h0, 32'h0, 0);
      total++; if (obs_req_first !== 1'b0) begin bad++; $display("FAIL flt%0d_no_req got=%b exp=0", i, obs_req_first); end
      total++; if (obs_req2 !== 1'b0) begin bad++; $display("FAIL flt%0d_no_req2 got=%b exp=0", i, obs_req2); end
      total++; if (obs_rv !== 1'b1) begin bad++; $display("FAIL flt%0d_rsp_valid got=%b exp=1", i, obs_rv); end
      total++; if (obs_fault !== 1'b1) begin bad++; $display("FAIL flt%0d_fault got=%b exp=1", i, obs_fault); end
      total++; if (obs_data !== 32'h0) begin bad++; $display("FAIL flt%0d_data got=%h exp=0", i, obs_data); end
      total++; if (obs_fault2 !== 1'b0) begin bad++; $display("FAIL flt%0d_fault_pulse got=%b exp=0", i, obs_fault2); end
      total++; if (obs_ready2 !== 1'b1) begin bad++; $display("FAIL flt%0d_ready_back got=%b exp=1", i, obs_ready2); end
    end
  endtask

  task automatic test_rst_in_wait();
    count_en = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h500;
    tick();
    req_valid = 1'b0;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rw_req_before got=%b exp=1", mem_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rw_req_after got=%b exp=0", mem_req); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rw_ready got=%b exp=1", req_ready); end
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_ack = 1'b0;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rw_stale_ack got=%b exp=0", rsp_valid); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rw_req_idle got=%b exp=0", mem_req); end
    tick();
    @(negedge clk); #1;
    total++; if (pulse_cnt != 0) begin bad++; $display("FAIL rw_pulses got=%0d exp=0", pulse_cnt); end
    total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL rw_rsp_data got=%h exp=0", rsp_data); end
    count_en = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    count_en = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300;
    tick();
    req_addr = 32'h304;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_busy got=%b exp=0", req_ready); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    total++; if (mem_addr !== 32'h300) begin bad++; $display("FAIL b2b_addr1 got=%h exp=00000300", mem_addr); end
    tick();
    total++; if (mem_addr !== 32'h300) begin bad++; $display("FAIL b2b_addr1_hold got=%h exp=00000300", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    mem_ack = 1'b0;
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL b2b_rv1 got=%b exp=1", rsp_valid); end
    total++; if (rsp_data !== 32'h1111_1111) begin bad++; $display("FAIL b2b_data1 got=%h exp=11111111", rsp_data); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_resp got=%b exp=0", req_ready); end
    tick();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_idle got=%b exp=1", req_ready); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL b2b_req_gap got=%b exp=0", mem_req); end
    tick();
    req_valid = 1'b0;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL b2b_req2 got=%b exp=1", mem_req); end
    total++; if (mem_addr !== 32'h304) begin bad++; $display("FAIL b2b_addr2 got=%h exp=00000304", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
    tick();
    mem_ack = 1'b0;
    total++; if (rsp_data !== 32'h2222_2222) begin bad++; $display("FAIL b2b_data2 got=%h exp=22222222", rsp_data); end
    tick(); tick();
    @(negedge clk); #1;
    total++; if (pulse_cnt != 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", pulse_cnt); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL b2b_no_third got=%b exp=0", mem_req); end
    count_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_fault();
    test_rst_in_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Load/store unit for the MEM stage. It sits directly upstream of the writeback select mux and produces the DMEM data word that the mux forwards to the register file.
- Accepts one memory op per handshake.
- Drives a word-addressed data-memory port with byte strobes and waits a variable number of cycles for ack.
- Aligns and sign/zero-extends load data.
- Flags misaligned or illegal ops without touching memory.

Parameters:
XLEN, 32, data width (fixed at 32; other values unsupported)
ADDR_W, 32, byte-address width

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  op request from execute stage
req_ready  output  1  unit can accept op this cycle
req_we  input  1  1=store, 0=load
req_funct3  input  3  RISC-V funct3 of the load/store
req_addr  input  ADDR_W  byte address
req_wdata  input  XLEN  store data (rs2)
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  word-aligned address ({req_addr[ADDR_W-1:2],2'b00})
mem_wstrb  output  4  byte strobes; 0000 on loads
mem_wdata  output  XLEN  lane-replicated store data
mem_ack  input  1  memory completion; load data valid same cycle
mem_rdata  input  XLEN  memory read word
rsp_valid  output  1  one-cycle completion pulse
rsp_data  output  XLEN  extended load result (DMEM input of WB mux); 0 for stores/faults
fault  output  1  one-cycle pulse with rsp_valid when op was misaligned/illegal
busy  output  1  ~req_ready; pipeline stall

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- Reset (sync): state=IDLE; mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_data=0, fault=0. Reset dominates all other inputs in the same cycle, including mid-WAIT; an outstanding ack is then ignored.
- req_ready=1 only in IDLE; req_valid outside IDLE is ignored (no queuing).
- Decode: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Any other funct3 is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- IDLE, accept (req_valid&req_ready) on a legal, aligned op:
  - Latch op; next state WAIT.
  - mem_req=1 from the next cycle, with mem_we/mem_addr/mem_wstrb/mem_wdata stable until ack.
- IDLE, accept on an illegal/misaligned op:
  - Next state RESP with fault=1, rsp_data=0. No mem_req is ever raised.
- Store strobes:
  - SB: 0001<<addr[1:0]; mem_wdata={4{wdata[7:0]}}.
  - SH: 0011<<addr[1:0]; mem_wdata={2{wdata[15:0]}}.
  - SW: 1111; mem_wdata=wdata.
- WAIT: hold everything until mem_ack=1.
  - On ack: mem_req drops next cycle; capture rsp_data; next state RESP.
  - No timeout; mem_ack in IDLE/RESP is ignored.
- Load extraction uses the latched addr[1:0]:
  - Byte at bits [8*a+7:8*a], halfword at [16*a[1]+15:16*a[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- RESP: rsp_valid=1 (and fault if set) for exactly one cycle, then IDLE. req_ready=1 in the following cycle.
- Latency: accept at cycle N, mem_req visible N+1, ack at M>=N+1, rsp_valid at M+1, next accept earliest M+2. Faulted op: rsp_valid at N+1.
- rsp_data holds its value until the next response; rsp_valid and fault are pulses.

Test Plan:
- LW addr=0x104, mem_rdata=0xDEADBEEF, ack after 3 cycles -> mem_addr=0x104, wstrb=0000, mem_req high exactly 3 cycles, rsp_valid one cycle later with rsp_data=0xDEADBEEF, fault=0.
- LB addr=0x203 and LBU addr=0x203, mem_rdata=0x80112233, ack immediate -> rsp_data=0xFFFFFF80 and 0x00000080 respectively; LH addr=0x202 -> 0xFFFF8011.
- SH addr=0x1002, wdata=0x0000ABCD -> mem_we=1, mem_addr=0x1000, wstrb=1100, mem_wdata=0xABCDABCD; after ack rsp_valid=1, rsp_data=0. SB addr=0x1001 wdata=0x5A -> wstrb=0010, mem_wdata=0x5A5A5A5A.
- LW addr=0x102 and funct3=011 -> no mem_req ever; rsp_valid and fault high one cycle after accept, rsp_data=0, req_ready back next cycle.
- Assert rst while in WAIT, then pulse mem_ack one cycle later -> mem_req=0 and req_ready=1 after the reset edge, no rsp_valid produced.
- Back-to-back: req_valid held high with a second LW queued while busy -> second op not accepted until the cycle after rsp_valid; exactly two rsp_valid pulses with correct data.
